demux_scan_1_n: RTL and testbench



---
 rtl/demux_scan_1_n.sv | 99 +++++++++
 tb/tb_demux_scan_1_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_1_n.sv
// Registered 1:N demultiplexer with enable, sticky range-error flag and an
// automatic scan mode that steps through every channel with a fixed dwell.
module demux_scan_1_n #(
  parameter int N_OUT   = 36,
  parameter int SEL_W   = 6,
  parameter int DWELL   = 1000,
  parameter bit REVERSE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] input_sel,
  input  logic             sel_load,
  input  logic             err_clr,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             frame_done,
  output logic             err
);

  // state | meaning
  // IDLE  | disabled, out forced low, cur_sel held
  // HOLD  | manual: cur_sel changes only on sel_load
  // SCAN  | automatic: cur_sel advances every DWELL cycles
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_OUT-1:0]   out_q, out_d;
  logic               fd_q, fd_d;
  logic               err_q, err_d;
  logic               load_ok, load_bad, scanning, expire;
  logic [SEL_W-1:0]   chan;

  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : HOLD;

    load_bad = sel_load && ({1'b0, input_sel} >= (SEL_W+1)'(N_OUT));
    load_ok  = sel_load && !load_bad;
    // Stepping only while staying in SCAN; entering or leaving clears the dwell.
    scanning = (state_q == SCAN) && (state_d == SCAN);
    expire   = (cnt_q == CNT_W'(DWELL - 1));

    sel_d = sel_q;
    cnt_d = '0;
    fd_d  = 1'b0;
    if (load_ok) begin
      sel_d = input_sel;
    end else if (scanning) begin
      if (expire) begin
        if (sel_q == SEL_W'(N_OUT - 1)) begin
          sel_d = '0;
          fd_d  = 1'b1;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A new error outranks a simultaneous clear.
    err_d = load_bad | (err_q & ~err_clr);

    chan  = REVERSE ? (SEL_W'(N_OUT - 1) - sel_q) : sel_q;
    out_d = '0;
    if (en && A) out_d[chan] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign out        = out_q;
  assign cur_sel    = sel_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_demux_scan_1_n.sv
// Scoreboard bench for demux_scan_1_n: one reversed and one straight-mapped
// instance share stimulus; a scan-position model predicts every cycle.
module tb_demux_scan_1_n;
  localparam int N  = 36;
  localparam int SW = 6;
  localparam int D  = 3;

  logic clk = 0, rst_n = 0, A = 0, en = 0, mode = 0, sel_load = 0, err_clr = 0;
  logic [SW-1:0] input_sel = '0;
  logic [N-1:0]  out_r, out_f;
  logic [SW-1:0] sel_r, sel_f;
  logic          fd_r, fd_f, err_r, err_f;

  demux_scan_1_n #(.N_OUT(N), .SEL_W(SW), .DWELL(D), .REVERSE(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .A(A), .en(en), .mode(mode), .input_sel(input_sel),
    .sel_load(sel_load), .err_clr(err_clr), .out(out_r), .cur_sel(sel_r),
    .frame_done(fd_r), .err(err_r));

  demux_scan_1_n #(.N_OUT(N), .SEL_W(SW), .DWELL(D), .REVERSE(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .A(A), .en(en), .mode(mode), .input_sel(input_sel),
    .sel_load(sel_load), .err_clr(err_clr), .out(out_f), .cur_sel(sel_f),
    .frame_done(fd_f), .err(err_f));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int fd_t0 = -1, fd_t1 = -1;

  typedef struct {
    int            cyc;
    logic [N-1:0]  o_r, o_f;
    logic [SW-1:0] sel;
    logic          fd, err;
  } exp_t;
  exp_t q[$];

  // Model: position in scan = anchor channel plus elapsed scan cycles / DWELL.
  int m_anchor = 0, m_phase = 0;
  bit m_scan = 0, m_err = 0;

  function automatic int m_sel();
    return (m_anchor + m_phase / D) % N;
  endfunction

  function automatic logic [N-1:0] onehot(int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fd_r) begin fd_t0 = fd_t1; fd_t1 = cyc; end
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("align", 64'(e.cyc), 64'(cyc));
        chk("out_rev", 64'(out_r), 64'(e.o_r));
        chk("out_fwd", 64'(out_f), 64'(e.o_f));
        chk("cur_sel", 64'(sel_r), 64'(e.sel));
        chk("cur_sel_fwd", 64'(sel_f), 64'(e.sel));
        chk("frame_done", 64'(fd_r), 64'(e.fd));
        chk("frame_done_fwd", 64'(fd_f), 64'(e.fd));
        chk("err", 64'(err_r), 64'(e.err));
      end
    end
  end

  task automatic drive(bit a, bit e, bit m, int s, bit ld, bit clr);
    exp_t x;
    bit   badld;
    int   cs;
    A = a; en = e; mode = m; input_sel = SW'(s); sel_load = ld; err_clr = clr;
    cs    = m_sel();
    badld = ld && (s >= N);
    x.o_r = (e && a) ? onehot(N - 1 - cs) : '0;
    x.o_f = (e && a) ? onehot(cs) : '0;
    m_err = badld ? 1'b1 : (clr ? 1'b0 : m_err);
    x.fd  = 1'b0;
    if (ld && !badld) begin
      m_anchor = s; m_phase = 0;
    end else if (m_scan && e && m) begin
      m_phase++;
      if (m_phase % D == 0 && m_sel() == 0) x.fd = 1'b1;
    end else begin
      m_anchor = cs; m_phase = 0;
    end
    m_scan = e && m;
    x.sel  = SW'(m_sel());
    x.err  = m_err;
    x.cyc  = cyc + 1;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    #2;
    chk("rst_out", 64'(out_r), 64'd0);
    chk("rst_sel", 64'(sel_r), 64'd0);
    chk("rst_fd", 64'(fd_r), 64'd0);
    chk("rst_err", 64'(err_r), 64'd0);
    @(posedge clk); #1 rst_n = 1;

    // Manual channel mapping
    drive(1, 1, 0, 35, 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("sel35_rev", 64'(out_r), 64'h1);
    chk("sel35_fwd", 64'(out_f), 64'h8_0000_0000);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("sel0_rev", 64'(out_r), 64'h8_0000_0000);
    drive(1, 1, 0, 5, 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("sel5_fwd", 64'(out_f), 64'h20);

    // HOLD on 10 with A toggling, then disable
    drive(1, 1, 0, 10, 1, 0);
    for (int i = 0; i < 8; i++) drive(bit'(i % 2), 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("dis_out", 64'(out_r), 64'd0);
    chk("dis_sel", 64'(sel_r), 64'd10);

    // Scan from 34, long enough for several frames
    drive(1, 1, 0, 34, 1, 0);
    for (int i = 0; i < 250; i++) drive(1, 1, 1, 0, 0, 0);
    chk("frame_len", 64'(fd_t1 - fd_t0), 64'(N * D));

    // Error flag
    drive(1, 1, 0, 40, 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("err_set", 64'(err_r), 64'd1);
    drive(1, 1, 0, 63, 1, 1);
    drive(1, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    chk("err_clr", 64'(err_r), 64'd0);

    // Load colliding with dwell expiry
    drive(1, 1, 1, 0, 1, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 7, 1, 0);
    chk("load_wins", 64'(sel_r), 64'd7);
    for (int i = 0; i < 7; i++) drive(1, 1, 1, 0, 0, 0);

    // Random
    for (int i = 0; i < 400; i++)
      drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 45)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

    // Asynchronous reset mid-scan at channel 20
    drive(1, 1, 1, 20, 1, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    chk("pre_rst_sel", 64'(sel_r), 64'd20);
    @(negedge clk); #1;
    A = 1; en = 1; mode = 1; sel_load = 0; err_clr = 0;
    rst_n = 0;
    #1;
    chk("arst_out", 64'(out_r), 64'd0);
    chk("arst_sel", 64'(sel_r), 64'd0);
    chk("arst_fd", 64'(fd_r), 64'd0);
    chk("arst_err", 64'(err_r), 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_out", 64'(out_f), 64'd0);
    rst_n = 1;
    m_anchor = 0; m_phase = 0; m_scan = 0; m_err = 0;
    for (int i = 0; i < 12; i++) drive(1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    if (q.size() != 0) chk("queue_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
